// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam logic [7:0]  RCON_INIT = 8'h01;
  localparam logic [7:0]  RCON_POLY = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_FINISH
  } ks_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box: GF(2^8) inverse followed by the affine map.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] plain,
  output logic [7:0] subst
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = '0;
    x   = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i[2:0]]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0 as the S-box requires.
  always_comb begin
    sq  = plain;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    subst = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: one round key per clock into an 11-entry register file.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] key,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  ks_state_e    state, state_d;
  logic         load, step, last_round;
  logic [3:0]   cnt;
  logic [7:0]   rcon;
  logic [127:0] prev, next_rk;
  logic [127:0] rk [0:NR];
  logic [31:0]  w0, w1, w2, w3, rot, sub, t, n0, n1, n2, n3;

  // prev mirrors rk[cnt-1], avoiding a second read mux on the register file.
  assign w0 = prev[127:96];
  assign w1 = prev[95:64];
  assign w2 = prev[63:32];
  assign w3 = prev[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .plain(rot[8*g +: 8]),
      .subst(sub[8*g +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};
  assign last_round = (cnt == 4'(NR));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        step = 1'b1;
        if (last_round) state_d = ST_FINISH;
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      keys_valid <= 1'b0;
      rk_out     <= '0;
      cnt        <= '0;
      rcon       <= RCON_INIT;
      prev       <= '0;
      for (int unsigned i = 0; i <= NR; i++) rk[i[3:0]] <= '0;
    end else begin
      busy <= (state_d == ST_EXPAND);
      done <= step && last_round;
      if (load) begin
        rk[0]      <= key;
        prev       <= key;
        cnt        <= 4'd1;
        rcon       <= RCON_INIT;
        keys_valid <= 1'b0;
      end else if (step) begin
        rk[cnt] <= next_rk;
        prev    <= next_rk;
        cnt     <= cnt + 4'd1;
        rcon    <= xtime(rcon);
        if (last_round) keys_valid <= 1'b1;
      end
      rk_out <= (rk_idx <= 4'(NR)) ? rk[rk_idx] : '0;
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed + randomized bench for aes_key_expand against a FIPS-197 word-schedule model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] key;
  logic         busy, done, keys_valid;
  logic [3:0]   rk_idx;
  logic [127:0] rk_out;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_rk [11];

  aes_key_expand #(.NR(10)) dut (
    .clk(clk), .reset(reset), .start(start), .key(key),
    .busy(busy), .done(done), .keys_valid(keys_valid),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Polynomial product with explicit long-division reduction by 0x11b.
  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int bit_n = 14; bit_n >= 8; bit_n--)
      if (p[bit_n]) p = p ^ (15'h11b << (bit_n - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] y, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int cand = 1; cand < 256; cand++)
        if (x != 0 && pmul(8'(x), 8'(cand)) == 8'h01) y = 8'(cand);
      for (int i = 0; i < 8; i++)
        s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8] ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox_tab[temp[31:24]], sbox_tab[temp[23:16]],
                sbox_tab[temp[15:8]], sbox_tab[temp[7:0]]} ^ {rcon_tab[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i);
      tick();
      chk($sformatf("%s_rk%0d", tag, i), rk_out, exp_rk[i]);
    end
  endtask

  // Accepts at E0 and steps through E11, checking busy/done timing each edge.
  task automatic run_expand(input string tag, input logic [127:0] k);
    key = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    key = {$urandom, $urandom, $urandom, $urandom};
    chk({tag, "_busy_e0"}, 128'(busy), 128'(1));
    chk({tag, "_kv_e0"}, 128'(keys_valid), 128'(0));
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("%s_done_e%0d", tag, e), 128'(done), 128'(e == 10));
      chk($sformatf("%s_busy_e%0d", tag, e), 128'(busy), 128'(e < 10));
    end
    chk({tag, "_kv_e10"}, 128'(keys_valid), 128'(1));
    tick();
    chk({tag, "_done_e11"}, 128'(done), 128'(0));
    chk({tag, "_kv_e11"}, 128'(keys_valid), 128'(1));
  endtask

  initial begin
    logic [127:0] k;
    int unsigned  done_cnt;

    reset = 1'b0; start = 1'b0; key = '0; rk_idx = '0;
    build_sbox();
    tick(); tick();
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_done", 128'(done), 128'(0));
    chk("idle_kv", 128'(keys_valid), 128'(0));
    for (int i = 0; i < 11; i++) exp_rk[i] = '0;
    read_all("idle");

    k = 128'h000102030405060708090a0b0c0d0e0f;
    model_expand(k);
    run_expand("k0", k);
    read_all("k0");
    chk("k0_vec_rk1", exp_rk[1], 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    chk("k0_vec_rk10", exp_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    model_expand(k);
    run_expand("k1", k);
    rk_idx = 4'd1; tick();
    chk("k1_rk1", rk_out, 128'ha0fafe1788542cb123a339392a6c7605);
    rk_idx = 4'd10; tick();
    chk("k1_rk10", rk_out, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    for (int i = 11; i < 16; i += 4) begin
      rk_idx = 4'(i); tick();
      chk($sformatf("oob_idx%0d", i), rk_out, '0);
    end

    // start pulses with new keys while busy must be ignored
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    key = k; start = 1'b1;
    tick();
    done_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      start = (e == 3 || e == 5);
      key = {$urandom, $urandom, $urandom, $urandom};
      tick();
      if (done) done_cnt++;
    end
    start = 1'b0;
    chk("busy_ign_done_cnt", 128'(done_cnt), 128'(1));
    read_all("busy_ign");

    // reset mid-expansion
    key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_done", 128'(done), 128'(0));
    chk("mid_rst_kv", 128'(keys_valid), 128'(0));
    chk("mid_rst_rkout", rk_out, '0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 11; i++) exp_rk[i] = '0;
    done_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      rk_idx = 4'(i); tick();
      if (done) done_cnt++;
      chk($sformatf("mid_rst_rk%0d", i), rk_out, '0);
    end
    chk("mid_rst_no_done", 128'(done_cnt), 128'(0));
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    run_expand("post_rst", k);
    read_all("post_rst");

    // start held high: restart on first IDLE edge after FINISH with the key present then
    key = {$urandom, $urandom, $urandom, $urandom}; start = 1'b1;
    tick();
    k = {$urandom, $urandom, $urandom, $urandom};
    key = k;
    repeat (10) tick();
    chk("hold_done_e10", 128'(done), 128'(1));
    tick();
    chk("hold_kv_e11", 128'(keys_valid), 128'(1));
    chk("hold_busy_e11", 128'(busy), 128'(0));
    tick();
    chk("hold_kv_e12", 128'(keys_valid), 128'(0));
    chk("hold_busy_e12", 128'(busy), 128'(1));
    start = 1'b0;
    key = '0;
    repeat (10) tick();
    chk("hold_done2", 128'(done), 128'(1));
    tick();
    model_expand(k);
    read_all("hold");

    for (int n = 0; n < 4; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      run_expand($sformatf("rnd%0d", n), k);
      read_all($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
